// File: rtl/rd_pntrs_and_empty.sv
// Read-side pointer, empty/almost-empty and used-word logic of the dual-clock FIFO.
// Owns the read pointer and brings the write Gray pointer into the read clock domain.
module rd_pntrs_and_empty #(
    parameter int unsigned AWIDTH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_LEVEL    = 2
) (
    input  logic              rd_clk_i,
    input  logic              aclr_n_i,
    input  logic              rd_req_i,
    input  logic [AWIDTH:0]   wr_pntr_gray_i,
    output logic [AWIDTH-1:0] rd_pntr_o,
    output logic [AWIDTH:0]   rd_pntr_gray_wr_o,
    output logic              rd_empty_o,
    output logic              rd_almost_empty_o,
    output logic [AWIDTH:0]   rd_usedw_o,
    output logic              rd_valid_o
);

    localparam int unsigned PW = AWIDTH + 1;

    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t AE_W = ptr_t'(AE_LEVEL);

    ptr_t bin_q, bin_d;
    ptr_t gray_q, gray_d;
    ptr_t usedw_q, usedw_d;
    ptr_t sync_q [SYNC_STAGES];
    ptr_t sync_d [SYNC_STAGES];
    ptr_t wr_sync;
    ptr_t wr_bin_sync;
    logic empty_q, empty_d;
    logic ae_q, ae_d;
    logic valid_q, valid_d;
    logic accept;

    // Next-state: pointer advance, write-pointer sync shift and flag derivation.
    always_comb begin
        accept    = rd_req_i & ~empty_q;
        bin_d     = bin_q + ptr_t'(accept);
        gray_d    = bin_d ^ (bin_d >> 1);
        sync_d[0] = wr_pntr_gray_i;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        wr_sync     = sync_q[SYNC_STAGES-1];
        wr_bin_sync = '0;
        for (int i = 0; i < int'(PW); i++) begin
            wr_bin_sync[i] = ^(wr_sync >> i);
        end
        usedw_d = wr_bin_sync - bin_d;
        empty_d = (gray_d == wr_sync);
        ae_d    = (usedw_d <= AE_W);
        valid_d = accept;
    end

    // State registers; reset clears everything at once.
    always_ff @(posedge rd_clk_i or negedge aclr_n_i) begin
        if (!aclr_n_i) begin
            bin_q   <= '0;
            gray_q  <= '0;
            usedw_q <= '0;
            empty_q <= 1'b1;
            ae_q    <= 1'b1;
            valid_q <= 1'b0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            usedw_q <= usedw_d;
            empty_q <= empty_d;
            ae_q    <= ae_d;
            valid_q <= valid_d;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        rd_pntr_o         = bin_q[AWIDTH-1:0];
        rd_pntr_gray_wr_o = gray_q;
        rd_empty_o        = empty_q;
        rd_almost_empty_o = ae_q;
        rd_usedw_o        = usedw_q;
        rd_valid_o        = valid_q;
    end

endmodule

// File: tb/tb_rd_pntrs_and_empty.sv
// Directed bench for rd_pntrs_and_empty with default parameters.
// Expected values are hand-derived; a random phase checks invariants.
module tb_rd_pntrs_and_empty;

    logic       clk;
    logic       aclr_n;
    logic       req;
    logic [4:0] wr_gray;
    logic [3:0] pntr;
    logic [4:0] gray_wr;
    logic       empty;
    logic       ae;
    logic [4:0] usedw;
    logic       valid;

    int errors = 0;
    int checks = 0;

    rd_pntrs_and_empty #(
        .AWIDTH(4),
        .SYNC_STAGES(2),
        .AE_LEVEL(2)
    ) dut (
        .rd_clk_i(clk),
        .aclr_n_i(aclr_n),
        .rd_req_i(req),
        .wr_pntr_gray_i(wr_gray),
        .rd_pntr_o(pntr),
        .rd_pntr_gray_wr_o(gray_wr),
        .rd_empty_o(empty),
        .rd_almost_empty_o(ae),
        .rd_usedw_o(usedw),
        .rd_valid_o(valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pntr"}, 32'(pntr), 0);
        check({tag, "_gray"}, 32'(gray_wr), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_ae"}, 32'(ae), 1);
        check({tag, "_usedw"}, 32'(usedw), 0);
        check({tag, "_valid"}, 32'(valid), 0);
    endtask

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    int          wr_total;
    int          valid_total;
    int          adv_total;
    logic [3:0]  prev_pntr;
    logic [4:0]  wr_bin;

    initial begin
        aclr_n  = 1'b1;
        req     = 1'b1;
        wr_gray = '0;
        #2;
        aclr_n  = 1'b0;
        #1;
        check_reset_vals("rst_async");
        step();
        step();
        check_reset_vals("rst_held");
        aclr_n = 1'b1;

        // Requests while empty are ignored.
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_empty", 32'(empty), 1);
            check("idle_usedw", 32'(usedw), 0);
            check("idle_pntr", 32'(pntr), 0);
            check("idle_valid", 32'(valid), 0);
        end

        // One word written just after edge 0; visible at edge 3.
        req     = 1'b0;
        wr_gray = g(5'd1);
        step();
        check("sync_e1_empty", 32'(empty), 1);
        step();
        check("sync_e2_empty", 32'(empty), 1);
        check("sync_e2_usedw", 32'(usedw), 0);
        step();
        check("sync_e3_empty", 32'(empty), 0);
        check("sync_e3_usedw", 32'(usedw), 1);
        check("sync_e3_ae", 32'(ae), 1);

        // Three words, four requests.
        wr_gray = g(5'd3);
        step();
        step();
        step();
        check("w3_usedw", 32'(usedw), 3);
        check("w3_ae", 32'(ae), 0);
        req = 1'b1;
        step();
        check("r1_pntr", 32'(pntr), 1);
        check("r1_valid", 32'(valid), 1);
        check("r1_usedw", 32'(usedw), 2);
        check("r1_empty", 32'(empty), 0);
        check("r1_ae", 32'(ae), 1);
        step();
        check("r2_pntr", 32'(pntr), 2);
        check("r2_valid", 32'(valid), 1);
        check("r2_usedw", 32'(usedw), 1);
        step();
        check("r3_pntr", 32'(pntr), 3);
        check("r3_valid", 32'(valid), 1);
        check("r3_usedw", 32'(usedw), 0);
        check("r3_empty", 32'(empty), 1);
        step();
        check("r4_pntr", 32'(pntr), 3);
        check("r4_valid", 32'(valid), 0);
        check("r4_empty", 32'(empty), 1);
        check("r4_gray", 32'(gray_wr), 32'(g(5'd3)));
        req = 1'b0;

        // Fresh start for the full-depth test.
        aclr_n  = 1'b0;
        wr_gray = '0;
        step();
        aclr_n = 1'b1;

        wr_gray = 5'b11000;
        step();
        step();
        step();
        check("full_usedw", 32'(usedw), 16);
        check("full_empty", 32'(empty), 0);
        check("full_ae", 32'(ae), 0);
        req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("fa_pntr", 32'(pntr), 32'(k % 16));
            check("fa_usedw", 32'(usedw), 32'(16 - k));
            check("fa_valid", 32'(valid), 1);
            check("fa_empty", 32'(empty), (k == 16) ? 1 : 0);
        end
        req = 1'b0;
        check("fa_gray_end", 32'(gray_wr), 32'h18);

        // Second lap: write pointer back at 0 after MSB toggle.
        wr_gray = 5'b00000;
        step();
        step();
        step();
        check("lap2_usedw", 32'(usedw), 16);
        check("lap2_empty", 32'(empty), 0);
        req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("fb_pntr", 32'(pntr), 32'(k % 16));
            check("fb_usedw", 32'(usedw), 32'(16 - k));
            check("fb_empty", 32'(empty), (k == 16) ? 1 : 0);
        end
        req = 1'b0;
        check("fb_gray_end", 32'(gray_wr), 0);
        step();
        check("fb_hold_empty", 32'(empty), 1);
        check("fb_hold_valid", 32'(valid), 0);

        // Almost-empty threshold: 5 words, read 3.
        wr_gray = g(5'd5);
        step();
        step();
        step();
        check("ae5_usedw", 32'(usedw), 5);
        check("ae5_ae", 32'(ae), 0);
        req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("ae_usedw", 32'(usedw), 32'(5 - k));
            check("ae_flag", 32'(ae), (k == 3) ? 1 : 0);
        end
        req = 1'b0;
        check("ae_pre_valid", 32'(valid), 1);
        check("ae_pre_pntr", 32'(pntr), 3);

        // Reset in mid-cycle acts without a clock edge.
        #3;
        aclr_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        wr_gray = '0;
        step();
        check_reset_vals("rst_mid_edge");
        aclr_n = 1'b1;

        // Random writer bounded by observed reads, random reader.
        wr_total    = 0;
        valid_total = 0;
        adv_total   = 0;
        prev_pntr   = '0;
        wr_bin      = '0;
        for (int c = 0; c < 10040; c++) begin
            step();
            check("rnd_usedw_le16", 32'(usedw <= 5'd16), 1);
            check("rnd_empty_eq", 32'(empty), 32'(usedw == 5'd0));
            if (valid) valid_total++;
            adv_total += int'(4'(pntr - prev_pntr));
            prev_pntr  = pntr;
            if (c < 10000) begin
                req = 1'($urandom_range(0, 1));
                if ((wr_total - valid_total) < 16 &&
                    $urandom_range(0, 1) == 1) begin
                    wr_bin   = wr_bin + 5'd1;
                    wr_total++;
                    wr_gray  = g(wr_bin);
                end
            end else begin
                req = 1'b1;
            end
        end
        check("rnd_valid_vs_adv", 32'(valid_total), 32'(adv_total));
        check("rnd_drained", 32'(valid_total), 32'(wr_total));
        check("rnd_final_empty", 32'(empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
